// File: rtl/fifo_rr_wr_arbiter_ctrl.sv
// Round-robin write arbiter and occupancy tracker for a shared flagless FIFO.
// Grants one requester per cycle and issues reads only when data is present.
module fifo_rr_wr_arbiter_ctrl #(
    parameter int REQ_NUM     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int VALID_WIDTH = 1,
    parameter int DEPTH       = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_en,
    input  logic [REQ_NUM-1:0]               i_req,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    i_data,
    input  logic [REQ_NUM*VALID_WIDTH-1:0]   i_valid,
    output logic [REQ_NUM-1:0]               o_gnt,
    input  logic                             i_rd_req,
    output logic                             o_rd_ack,
    output logic                             o_fifo_en,
    output logic                             o_fifo_wr,
    output logic                             o_fifo_rd,
    output logic [DATA_WIDTH-1:0]            o_fifo_data,
    output logic [VALID_WIDTH-1:0]           o_fifo_valid,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [CW-1:0]          count_reg, count_next;
    logic [PW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]          sel_idx;
    logic [PW:0]            scan_idx;
    logic                   full, empty, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]  data_arr  [REQ_NUM];
    logic [VALID_WIDTH-1:0] valid_arr [REQ_NUM];

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Held in reset, nothing may be granted or read even if requests are present.
    assign wr_ok = rst_n & i_en & ~full & (|i_req);
    assign rd_ok = rst_n & i_en & i_rd_req & ~empty;

    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
            assign data_arr[gi]  = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign valid_arr[gi] = i_valid[gi*VALID_WIDTH +: VALID_WIDTH];
            assign o_gnt[gi]     = wr_ok & (sel_idx == PW'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        sel_idx  = '0;
        scan_idx = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(i);
            if (scan_idx >= (PW+1)'(REQ_NUM))
                scan_idx = scan_idx - (PW+1)'(REQ_NUM);
            if (i_req[scan_idx[PW-1:0]])
                sel_idx = scan_idx[PW-1:0];
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        count_next  = count_reg;
        if (wr_ok)
            rr_ptr_next = (sel_idx == PW'(REQ_NUM - 1)) ? '0 : sel_idx + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign o_fifo_en    = i_en;
    assign o_fifo_wr    = wr_ok;
    assign o_fifo_rd    = rd_ok;
    assign o_rd_ack     = rd_ok;
    assign o_fifo_data  = wr_ok ? data_arr[sel_idx]  : '0;
    assign o_fifo_valid = wr_ok ? valid_arr[sel_idx] : '0;
    assign o_count      = count_reg;
    assign o_full       = full;
    assign o_empty      = empty;

endmodule
